alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Sequencer between the instruction decoder and the 8-bit ALU/register file.
- Accepts one ALU instruction per handshake and reads the source registers from the register file.
- Drives the ALU operand, operation and enable lines for exactly one cycle, latches the result, then writes it back to the destination register.
- Flags illegal operations and divide-by-zero instead of executing them.

Parameters:
- NREG, 8, number of general registers; register address width is $clog2(NREG).
- DW, 8, data width; must match the ALU bus width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- req_valid  in  1  instruction request valid.
- req_ready  out  1  sequencer can accept a request.
- req_opr  in  4  ALU operation code: ADD=0 SUB=1 MUL=2 DIV=3 AND=4 OR=5 XOR=6 CMP=7 INC=8 DEC=9 NOT=10 SHL=11 SHR=12 RTR=13 RTL=14.
- req_dst  in  AW  destination register; also the A source.
- req_src  in  AW  B source register.
- req_imm_en  in  1  use req_imm as the B operand instead of the register.
- req_imm  in  DW  immediate operand.
- rf_addr_a  out  AW  register-file read address A (combinational read).
- rf_data_a  in  DW  register-file read data A.
- rf_addr_b  out  AW  register-file read address B.
- rf_data_b  in  DW  register-file read data B.
- rf_wr_en  out  1  register-file write strobe.
- rf_wr_addr  out  AW  write address.
- rf_wr_data  out  DW  write data.
- alu_a  out  DW  ALU A operand.
- alu_b  out  DW  ALU B operand.
- alu_opr  out  4  ALU operation.
- alu_en  out  1  ALU enable.
- alu_direct  out  DW  ALU direct (immediate) data.
- alu_direct_en  out  1  ALU direct-data select.
- alu_out  in  DW  ALU result.
- done  out  1  one-cycle pulse: instruction retired.
- err  out  1  qualifies done: instruction rejected, no write.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE. The following are 0: req_ready, rf_wr_en, alu_en, alu_direct_en, done, err, and all operand and result latches. Reset mid-instruction aborts it with no write.
- States: IDLE, READ, EXEC, WB.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch opr, dst, src, imm_en and imm, then go to READ.
- READ:
  - rf_addr_a=dst, rf_addr_b=src.
  - Latch A=rf_data_a, and B=imm if imm_en else rf_data_b.
  - Next state is WB with err=1 if either:
    - opr==15 (illegal), or
    - opr==DIV and B==0.
  - Otherwise go to EXEC.
- EXEC:
  - alu_en=1 for exactly this cycle; alu_opr=opr, alu_a=A.
  - If imm_en: alu_b=0, alu_direct=B, alu_direct_en=1. Else: alu_b=B, alu_direct_en=0.
  - Capture alu_out into the result latch on the closing edge. The ALU updates its status word on this same edge for CMP.
- WB:
  - done=1.
  - rf_wr_en=1 with rf_wr_addr=dst and rf_wr_data=result, except when opr==CMP or err=1 (then rf_wr_en=0).
  - Next state IDLE; err clears on leaving WB.
- Latency: accept at edge N; EXEC is cycle N+2; done/write in cycle N+3; req_ready high again in cycle N+4. Throughput is one instruction per 4 cycles.
- Unary ops (INC..RTL) still read and latch B; the ALU ignores it.
- Arithmetic wraps mod 2^DW. The sequencer does no arithmetic itself.
- alu_en, rf_wr_en and done are never high outside EXEC/WB. req_valid outside IDLE is ignored (not latched).
- Error outcomes (illegal opr, divide-by-zero) complete in 3 cycles, skipping EXEC; alu_en stays 0.

Optional Feature:
- Macro ALU_SEQ_FWD_EN.
- When defined:
  - req_ready=1 also in WB, so a request can be accepted during WB and the next state is READ (throughput one instruction per 3 cycles).
  - In that READ, if the new dst or src equals the retiring register (last write with rf_wr_en=1), the corresponding operand takes the written result instead of register-file data.
- When undefined: req_ready=1 only in IDLE; no forwarding logic.

Test Plan:
- Reset then ADD: R1=0x7F, R2=0x01, ADD dst=1 src=2 -> alu_en=1 for one cycle, then done with R1=0x80, err=0, 3 cycles after accept.
- CMP: R3=5, imm 5, req_imm_en=1 -> alu_direct_en=1 and alu_direct=5 in EXEC; done with no rf_wr_en; ALU status word E=1.
- DIV: R4=9, R5=0, DIV -> done+err in cycle N+2, alu_en never asserted, R4 still 9; opr=15 behaves the same.
- Overflow and rotate:
  - INC on R6=0xFF -> R6=0x00.
  - RTL on 0x81 -> 0x03.
- Abort and ignore:
  - rst_n low during EXEC -> all outputs 0 immediately; no write; next request executes normally.
  - req_valid held high during READ/EXEC -> not accepted until IDLE.
- With ALU_SEQ_FWD_EN: INC R1 (R1=1) immediately followed by INC R1 -> second accepted in WB; final R1=3; second done 3 cycles after first.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: instruction request handshake between the decoder (master) and alu_seq (slave).
interface alu_seq_if #(
    parameter int AW = 3,
    parameter int DW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_opr;
    logic [AW-1:0] req_dst;
    logic [AW-1:0] req_src;
    logic          req_imm_en;
    logic [DW-1:0] req_imm;
    modport master (
        output req_valid, req_opr, req_dst, req_src, req_imm_en, req_imm,
        input  req_ready
    );
    modport slave (
        input  req_valid, req_opr, req_dst, req_src, req_imm_en, req_imm,
        output req_ready
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: IDLE/READ/EXEC/WB sequencer driving the ALU and writing results back to the register file.
// Optional ALU_SEQ_FWD_EN: accept during WB and forward the retiring write into the next READ.
module alu_seq #(
    parameter int NREG = 8,
    parameter int DW   = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_if.slave      req,
    output logic [AW-1:0] rf_addr_a,
    input  logic [DW-1:0] rf_data_a,
    output logic [AW-1:0] rf_addr_b,
    input  logic [DW-1:0] rf_data_b,
    output logic          rf_wr_en,
    output logic [AW-1:0] rf_wr_addr,
    output logic [DW-1:0] rf_wr_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_opr,
    output logic          alu_en,
    output logic [DW-1:0] alu_direct,
    output logic          alu_direct_en,
    input  logic [DW-1:0] alu_out,
    output logic          done,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_CMP = 4'd7;
    localparam logic [3:0] OP_BAD = 4'd15;
`ifdef ALU_SEQ_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif
    state_t        state;
    logic [3:0]    opr;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic          imm_en;
    logic [DW-1:0] imm;
    logic [DW-1:0] a_val;
    logic [DW-1:0] b_val;
    logic          bad;
    logic          accept;
    assign rf_addr_a = dst;
    assign rf_addr_b = src;
`ifdef ALU_SEQ_FWD_EN
    // fwd_vld marks the READ that directly follows a retiring write
    logic fwd_vld;
    assign a_val = (fwd_vld && rf_wr_addr == dst) ? rf_wr_data : rf_data_a;
    assign b_val = imm_en ? imm : (fwd_vld && rf_wr_addr == src) ? rf_wr_data : rf_data_b;
`else
    assign a_val = rf_data_a;
    assign b_val = imm_en ? imm : rf_data_b;
`endif
    assign bad    = opr == OP_BAD || (opr == OP_DIV && b_val == '0);
    assign accept = req.req_valid && req.req_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req.req_ready <= 1'b0;
            opr           <= '0;
            dst           <= '0;
            src           <= '0;
            imm_en        <= 1'b0;
            imm           <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_opr       <= '0;
            alu_en        <= 1'b0;
            alu_direct    <= '0;
            alu_direct_en <= 1'b0;
            rf_wr_en      <= 1'b0;
            rf_wr_addr    <= '0;
            rf_wr_data    <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
`ifdef ALU_SEQ_FWD_EN
            fwd_vld       <= 1'b0;
`endif
        end else begin
            alu_en        <= 1'b0;
            alu_direct_en <= 1'b0;
            rf_wr_en      <= 1'b0;
            done          <= 1'b0;
`ifdef ALU_SEQ_FWD_EN
            fwd_vld       <= 1'b0;
`endif
            case (state)
                IDLE, WB: begin
                    err <= 1'b0;
                    if (accept) begin
                        opr           <= req.req_opr;
                        dst           <= req.req_dst;
                        src           <= req.req_src;
                        imm_en        <= req.req_imm_en;
                        imm           <= req.req_imm;
                        req.req_ready <= 1'b0;
                        state         <= READ;
`ifdef ALU_SEQ_FWD_EN
                        fwd_vld       <= rf_wr_en;
`endif
                    end else begin
                        req.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                READ: begin
                    if (bad) begin
                        err           <= 1'b1;
                        done          <= 1'b1;
                        req.req_ready <= FWD;
                        state         <= WB;
                    end else begin
                        alu_a         <= a_val;
                        alu_b         <= imm_en ? '0 : b_val;
                        alu_direct    <= imm_en ? b_val : '0;
                        alu_opr       <= opr;
                        alu_en        <= 1'b1;
                        alu_direct_en <= imm_en;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    rf_wr_data    <= alu_out;
                    rf_wr_addr    <= dst;
                    rf_wr_en      <= opr != OP_CMP;
                    done          <= 1'b1;
                    req.req_ready <= FWD;
                    state         <= WB;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq against a behavioural register file and ALU.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.AW(3), .DW(8)) bus ();

    logic [2:0] rf_addr_a, rf_addr_b, rf_wr_addr;
    logic [7:0] rf_data_a, rf_data_b, rf_wr_data, alu_a, alu_b, alu_direct, alu_out, bop;
    logic [3:0] alu_opr;
    logic       rf_wr_en, alu_en, alu_direct_en, done, err;

    alu_seq #(.NREG(8), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(bus),
        .rf_addr_a(rf_addr_a), .rf_data_a(rf_data_a),
        .rf_addr_b(rf_addr_b), .rf_data_b(rf_data_b),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opr(alu_opr), .alu_en(alu_en),
        .alu_direct(alu_direct), .alu_direct_en(alu_direct_en), .alu_out(alu_out),
        .done(done), .err(err)
    );

    logic [7:0] rf [8];
    logic       pl_en = 1'b0;
    logic [2:0] pl_addr = '0;
    logic [7:0] pl_data = '0;
    logic       eq_flag = 1'b0;
    int         alu_en_cnt = 0;
    int         wr_cnt = 0;

    assign rf_data_a = rf[rf_addr_a];
    assign rf_data_b = rf[rf_addr_b];

    always_comb begin
        bop = alu_direct_en ? alu_direct : alu_b;
        case (alu_opr)
            4'd0:    alu_out = alu_a + bop;
            4'd1:    alu_out = alu_a - bop;
            4'd2:    alu_out = 8'(alu_a * bop);
            4'd3:    alu_out = (bop == 0) ? 8'hFF : alu_a / bop;
            4'd4:    alu_out = alu_a & bop;
            4'd5:    alu_out = alu_a | bop;
            4'd6:    alu_out = alu_a ^ bop;
            4'd7:    alu_out = alu_a;
            4'd8:    alu_out = alu_a + 8'd1;
            4'd9:    alu_out = alu_a - 8'd1;
            4'd10:   alu_out = ~alu_a;
            4'd11:   alu_out = {alu_a[6:0], 1'b0};
            4'd12:   alu_out = {1'b0, alu_a[7:1]};
            4'd13:   alu_out = {alu_a[0], alu_a[7:1]};
            4'd14:   alu_out = {alu_a[6:0], alu_a[7]};
            default: alu_out = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        if (rf_wr_en) begin
            rf[rf_wr_addr] <= rf_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (alu_en) begin
            alu_en_cnt <= alu_en_cnt + 1;
            if (alu_opr == 4'd7) eq_flag <= (alu_a == bop);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic       ex_de;
    logic [7:0] ex_dv, ex_bv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [3:0] o, input logic [2:0] d, input logic [2:0] s,
                         input logic ie, input logic [7:0] im, input bit hold);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_opr = o; bus.req_dst = d; bus.req_src = s;
        bus.req_imm_en = ie; bus.req_imm = im;
        for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
        chk("accept", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic run(input string tag, input logic [3:0] o, input logic [2:0] d, input logic [2:0] s,
                       input logic ie, input logic [7:0] im, input int exp_lat, input logic exp_err,
                       input logic [7:0] exp_val);
        int e0, w0, lat;
        logic e;
        e0 = alu_en_cnt; w0 = wr_cnt; lat = 0; e = 1'b0; ex_de = 1'b0; ex_dv = '0; ex_bv = '0;
        issue(o, d, s, ie, im, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (alu_en) begin ex_de = alu_direct_en; ex_dv = alu_direct; ex_bv = alu_b; end
            if (done) begin lat = k; e = err; break; end
        end
        @(negedge clk);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
        chk({tag, "_val"}, {24'd0, rf[d]}, {24'd0, exp_val});
        chk({tag, "_alu_en"}, alu_en_cnt - e0, exp_err ? 0 : 1);
        chk({tag, "_wr"}, wr_cnt - w0, (exp_err || o == 4'd7) ? 0 : 1);
        chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0, w0, d1, d2;
        bus.req_valid = 1'b0; bus.req_opr = '0; bus.req_dst = '0; bus.req_src = '0;
        bus.req_imm_en = 1'b0; bus.req_imm = '0;
        @(negedge clk);
        chk("reset_ctl", {26'd0, bus.req_ready, done, err, rf_wr_en, alu_en, alu_direct_en}, 32'd0);
        chk("reset_data", {rf_wr_data, alu_a, alu_b, alu_direct}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);
        load(3'd1, 8'h7F); load(3'd2, 8'h01); load(3'd3, 8'h05); load(3'd4, 8'h09);
        load(3'd5, 8'h00); load(3'd6, 8'hFF); load(3'd7, 8'h81); load(3'd0, 8'h00);
        run("add", 4'd0, 3'd1, 3'd2, 1'b0, 8'h00, 3, 1'b0, 8'h80);
        run("cmp", 4'd7, 3'd3, 3'd0, 1'b1, 8'h05, 3, 1'b0, 8'h05);
        chk("cmp_direct_en", {31'd0, ex_de}, 32'd1);
        chk("cmp_direct", {24'd0, ex_dv}, 32'h05);
        chk("cmp_alu_b", {24'd0, ex_bv}, 32'h00);
        chk("cmp_eq_flag", {31'd0, eq_flag}, 32'd1);
        run("div0", 4'd3, 3'd4, 3'd5, 1'b0, 8'h00, 2, 1'b1, 8'h09);
        run("illegal", 4'd15, 3'd4, 3'd2, 1'b0, 8'h00, 2, 1'b1, 8'h09);
        run("div_imm", 4'd3, 3'd4, 3'd0, 1'b1, 8'h02, 3, 1'b0, 8'h04);
        run("inc_wrap", 4'd8, 3'd6, 3'd0, 1'b0, 8'h00, 3, 1'b0, 8'h00);
        run("rtl", 4'd14, 3'd7, 3'd0, 1'b0, 8'h00, 3, 1'b0, 8'h03);
        run("rtr", 4'd13, 3'd7, 3'd0, 1'b0, 8'h00, 3, 1'b0, 8'h81);
        run("sub_wrap", 4'd1, 3'd0, 3'd0, 1'b1, 8'h01, 3, 1'b0, 8'hFF);
        // reset during EXEC must abort without a write
        w0 = wr_cnt;
        issue(4'd0, 3'd1, 3'd2, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_exec", {31'd0, alu_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {27'd0, bus.req_ready, done, err, rf_wr_en, alu_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_no_write", wr_cnt - w0, 0);
        chk("abort_reg", {24'd0, rf[1]}, 32'h80);
        run("after_abort", 4'd0, 3'd1, 3'd2, 1'b0, 8'h00, 3, 1'b0, 8'h81);
        // req_valid held high: second INC accepted only when the sequencer is ready again
        load(3'd1, 8'h01);
        e0 = alu_en_cnt; d1 = 0; d2 = 0;
        issue(4'd8, 3'd1, 3'd0, 1'b0, 8'h00, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) chk("held_ready_read", {31'd0, bus.req_ready}, 32'd0);
            if (k == 2) chk("held_ready_exec", {31'd0, bus.req_ready}, 32'd0);
            if (done) begin
                if (d1 == 0) d1 = k;
                else if (d2 == 0) d2 = k;
            end
            if (k == 5) bus.req_valid = 1'b0;
        end
        chk("held_first_done", d1, 3);
`ifdef ALU_SEQ_FWD_EN
        chk("held_gap", d2 - d1, 3);
`else
        chk("held_gap", d2 - d1, 4);
`endif
        chk("held_alu_en", alu_en_cnt - e0, 2);
        chk("held_result", {24'd0, rf[1]}, 32'h03);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
